// File: rtl/store_drain_buffer.sv
// In-order store buffer draining to a data memory, with load hazard checking and sign/zero extension.
// Optional store-to-load forwarding is compiled in when STBUF_FWD_EN is defined.
module store_drain_buffer #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [63:0] st_addr,
  input  logic [63:0] st_data,
  input  logic [3:0]  st_size,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [63:0] ld_addr,
  input  logic [3:0]  ld_size,
  input  logic        ld_signed,
  output logic        ld_rvalid,
  output logic [63:0] ld_rdata,
  output logic        empty,
  output logic [63:0] mem_addr_load,
  output logic [63:0] mem_addr_store,
  output logic        mem_write_enable,
  output logic [63:0] mem_write_data,
  output logic [3:0]  mem_xfer_size,
  input  logic [63:0] mem_read_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_MAX + 1);

  function automatic logic [3:0] norm_size(input logic [3:0] s);
    case (s)
      4'd1, 4'd2, 4'd4: return s;
      default:          return 4'd8;
    endcase
  endfunction

  function automatic logic [63:0] align(input logic [63:0] a, input logic [3:0] s);
    case (norm_size(s))
      4'd1:    return a;
      4'd2:    return {a[63:1], 1'b0};
      4'd4:    return {a[63:2], 2'b0};
      default: return {a[63:3], 3'b0};
    endcase
  endfunction

  function automatic logic [63:0] extend(input logic [63:0] d, input logic [3:0] s, input logic sgn);
    case (norm_size(s))
      4'd1:    return {{56{sgn & d[7]}}, d[7:0]};
      4'd2:    return {{48{sgn & d[15]}}, d[15:0]};
      4'd4:    return {{32{sgn & d[31]}}, d[31:0]};
      default: return d;
    endcase
  endfunction

  logic [63:0] addr_mem [DEPTH];
  logic [63:0] data_mem [DEPTH];
  logic [3:0]  size_mem [DEPTH];

  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic [CW-1:0] starve_cnt;

  logic [63:0] ld_al;
  logic [3:0]  ld_sz;
  logic        push, drain_go, ld_accept, hazard, starved;
  logic [63:0] ld_src;
  logic [DEPTH-1:0] ent_overlap;

  assign ld_al     = align(ld_addr, ld_size);
  assign ld_sz     = norm_size(ld_size);
  assign empty     = (count == '0);
  assign st_ready  = (count != (AW+1)'(DEPTH));
  assign push      = st_valid && st_ready;
  assign starved   = (starve_cnt == CW'(STARVE_MAX));
  assign ld_ready  = !hazard && !starved;
  assign ld_accept = ld_valid && ld_ready;
  assign drain_go  = !empty && !ld_accept;

  assign mem_addr_load    = ld_al;
  assign mem_write_enable = drain_go;
  assign mem_addr_store   = addr_mem[head];
  assign mem_write_data   = data_mem[head];
  assign mem_xfer_size    = ld_accept ? ld_size : (empty ? 4'd8 : size_mem[head]);

  // Only entries already resident this cycle take part; 65-bit sums avoid wrap at the top of memory.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic [AW-1:0] offset;
    logic          ent_valid;
    assign offset    = AW'(gi) - head;
    assign ent_valid = ({1'b0, offset} < count);
    assign ent_overlap[gi] = ent_valid &&
        ({1'b0, ld_al} < ({1'b0, addr_mem[gi]} + 65'(size_mem[gi]))) &&
        ({1'b0, addr_mem[gi]} < ({1'b0, ld_al} + 65'(ld_sz)));
  end

`ifdef STBUF_FWD_EN
  logic [DEPTH-1:0] ent_match;
  logic [AW-1:0]    fwd_idx;
  logic             fwd_hit;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign ent_match[gi] = (addr_mem[gi] == ld_al) && (size_mem[gi] == ld_sz);
  end

  // Walk oldest to youngest so the last overlapping entry seen decides forwardability.
  always_comb begin
    fwd_idx = head;
    fwd_hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_overlap[head + AW'(k)]) begin
        fwd_idx = head + AW'(k);
        fwd_hit = ent_match[head + AW'(k)];
      end
    end
  end

  assign hazard = (|ent_overlap) && !fwd_hit;
  assign ld_src = fwd_hit ? data_mem[fwd_idx] : mem_read_data;
`else
  assign hazard = |ent_overlap;
  assign ld_src = mem_read_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      starve_cnt <= '0;
      ld_rvalid  <= 1'b0;
      ld_rdata   <= '0;
    end else begin
      if (push)     tail <= tail + 1'b1;
      if (drain_go) head <= head + 1'b1;
      case ({push, drain_go})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      starve_cnt <= (!empty && ld_accept) ? starve_cnt + 1'b1 : '0;
      ld_rvalid  <= ld_accept;
      if (ld_accept) ld_rdata <= extend(ld_src, ld_size, ld_signed);
    end
  end

  // Payload storage carries no reset; occupancy is tracked by head/count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= align(st_addr, st_size);
      data_mem[tail] <= st_data;
      size_mem[tail] <= norm_size(st_size);
    end
  end
endmodule

// File: tb/tb_store_drain_buffer.sv
// Directed bench for store_drain_buffer with a byte-addressed memory model on the mem_* port.
// Expectations for the forwarding case follow STBUF_FWD_EN.
module tb_store_drain_buffer;
  logic        clk, rst_n;
  logic        st_valid, st_ready;
  logic [63:0] st_addr, st_data;
  logic [3:0]  st_size;
  logic        ld_valid, ld_ready;
  logic [63:0] ld_addr;
  logic [3:0]  ld_size;
  logic        ld_signed, ld_rvalid;
  logic [63:0] ld_rdata;
  logic        empty;
  logic [63:0] mem_addr_load, mem_addr_store, mem_write_data, mem_read_data;
  logic        mem_write_enable;
  logic [3:0]  mem_xfer_size;

  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  int wr_before;
  int drain_cycle;
  logic [7:0] mem [1024];

  store_drain_buffer #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_size(ld_size), .ld_signed(ld_signed),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .empty(empty),
    .mem_addr_load(mem_addr_load), .mem_addr_store(mem_addr_store), .mem_write_enable(mem_write_enable),
    .mem_write_data(mem_write_data), .mem_xfer_size(mem_xfer_size), .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian byte memory; reads are combinational, writes land on the clock edge.
  always_comb begin
    mem_read_data = '0;
    for (int b = 0; b < 8; b++) mem_read_data[8*b +: 8] = mem[mem_addr_load[9:0] + 10'(b)];
  end

  always @(posedge clk) begin
    if (mem_write_enable) begin
      for (int b = 0; b < 8; b++)
        if (b < int'(mem_xfer_size)) mem[mem_addr_store[9:0] + 10'(b)] = mem_write_data[8*b +: 8];
      wr_count = wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = 4'd8;
    ld_valid = 1'b0; ld_addr = '0; ld_size = 4'd8; ld_signed = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

    // Reset state
    #12;
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_st_ready", 64'(st_ready), 64'd1);
    check("rst_we", 64'(mem_write_enable), 64'd0);
    check("rst_rvalid", 64'(ld_rvalid), 64'd0);
    check("rst_rdata", ld_rdata, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fill the FIFO while accepted loads hold off the drain, then watch it drain in order
    ld_valid = 1'b1; ld_addr = 64'h300; ld_size = 4'd8;
    for (int i = 0; i < 4; i++) begin
      st_valid = 1'b1; st_addr = 64'(i * 8); st_data = 64'hA000 + 64'(i); st_size = 4'd8;
      @(negedge clk);
      check("fill_st_ready", 64'(st_ready), 64'd1);
      check("fill_no_drain", 64'(mem_write_enable), 64'd0);
      tick();
    end
    ld_valid = 1'b0; st_addr = 64'h20; st_data = 64'hBAD;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) check("full_st_ready", 64'(st_ready), 64'd0);
      check("drain_we", 64'(mem_write_enable), 64'd1);
      check("drain_addr", mem_addr_store, 64'(i * 8));
      check("drain_data", mem_write_data, 64'hA000 + 64'(i));
      check("drain_size", 64'(mem_xfer_size), 64'd8);
      $display("drain %0d addr=%h data=%h", i, mem_addr_store, mem_write_data);
      tick();
      st_valid = 1'b0;
    end
    @(negedge clk);
    check("drained_empty", 64'(empty), 64'd1);
    check("drained_we", 64'(mem_write_enable), 64'd0);
    tick();

    // Byte load with sign and zero extension
    st_valid = 1'b1; st_addr = 64'h40; st_data = 64'hFFFF_FFFF_FFFF_FF80; st_size = 4'd8;
    tick();
    st_valid = 1'b0;
    @(negedge clk);
    check("ext_drain_addr", mem_addr_store, 64'h40);
    tick();
    ld_valid = 1'b1; ld_addr = 64'h40; ld_size = 4'd1; ld_signed = 1'b1;
    @(negedge clk);
    check("ext_ld_ready", 64'(ld_ready), 64'd1);
    check("ext_xfer_size", 64'(mem_xfer_size), 64'd1);
    tick();
    ld_signed = 1'b0;
    @(negedge clk);
    check("ext_s_rvalid", 64'(ld_rvalid), 64'd1);
    check("ext_s_rdata", ld_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    $display("load signed byte 0x40 rdata=%h", ld_rdata);
    tick();
    ld_valid = 1'b0;
    @(negedge clk);
    check("ext_u_rvalid", 64'(ld_rvalid), 64'd1);
    check("ext_u_rdata", ld_rdata, 64'h80);
    $display("load unsigned byte 0x40 rdata=%h", ld_rdata);
    tick();
    @(negedge clk);
    check("idle_rvalid", 64'(ld_rvalid), 64'd0);
    check("idle_rdata_hold", ld_rdata, 64'h80);
    tick();

    // Load hitting a buffered store of identical address and size
    st_valid = 1'b1; st_addr = 64'h100; st_data = 64'h1122_3344_5566_7788; st_size = 4'd8;
    tick();
    st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 64'h100; ld_size = 4'd8; ld_signed = 1'b0;
    @(negedge clk);
`ifdef STBUF_FWD_EN
    check("fwd_ld_ready", 64'(ld_ready), 64'd1);
    check("fwd_no_drain", 64'(mem_write_enable), 64'd0);
    tick();
    ld_valid = 1'b0;
    @(negedge clk);
    check("fwd_rvalid", 64'(ld_rvalid), 64'd1);
    check("fwd_rdata", ld_rdata, 64'h1122_3344_5566_7788);
    check("fwd_late_drain", 64'(mem_write_enable), 64'd1);
    $display("load 0x100 forwarded rdata=%h", ld_rdata);
    tick();
`else
    check("stall_ld_ready", 64'(ld_ready), 64'd0);
    check("stall_drain", 64'(mem_write_enable), 64'd1);
    tick();
    @(negedge clk);
    check("stall_ld_ready_after", 64'(ld_ready), 64'd1);
    tick();
    ld_valid = 1'b0;
    @(negedge clk);
    check("stall_rvalid", 64'(ld_rvalid), 64'd1);
    check("stall_rdata", ld_rdata, 64'h1122_3344_5566_7788);
    $display("load 0x100 from memory rdata=%h", ld_rdata);
    tick();
`endif
    @(negedge clk);
    check("t3_empty", 64'(empty), 64'd1);
    tick();

    // Partial overlap: must stall, drain, then read memory
    st_valid = 1'b1; st_addr = 64'h200; st_data = 64'hCAFE_BABE_1234_5678; st_size = 4'd8;
    tick();
    st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 64'h204; ld_size = 4'd4; ld_signed = 1'b1;
    @(negedge clk);
    check("part_ld_ready", 64'(ld_ready), 64'd0);
    check("part_drain", 64'(mem_write_enable), 64'd1);
    check("part_drain_addr", mem_addr_store, 64'h200);
    tick();
    @(negedge clk);
    check("part_ld_ready_after", 64'(ld_ready), 64'd1);
    check("part_mem_addr_load", mem_addr_load, 64'h204);
    tick();
    ld_valid = 1'b0;
    @(negedge clk);
    check("part_rvalid", 64'(ld_rvalid), 64'd1);
    check("part_rdata", ld_rdata, 64'hFFFF_FFFF_CAFE_BABE);
    $display("load word 0x204 rdata=%h", ld_rdata);
    tick();

    // Starvation guard: one buffered store, loads held continuously
    st_valid = 1'b1; st_addr = 64'h280; st_data = 64'h55; st_size = 4'd8;
    ld_valid = 1'b1; ld_addr = 64'h300; ld_size = 4'd8; ld_signed = 1'b0;
    @(negedge clk);
    check("starve_first_ready", 64'(ld_ready), 64'd1);
    tick();
    st_valid = 1'b0;
    drain_cycle = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_write_enable && drain_cycle == 0) drain_cycle = c;
      check("starve_ld_ready", 64'(ld_ready), (c == 9) ? 64'd0 : 64'd1);
      check("starve_we", 64'(mem_write_enable), (c == 9) ? 64'd1 : 64'd0);
      tick();
    end
    ld_valid = 1'b0;
    $display("starvation drain at cycle %0d", drain_cycle);
    check("starve_drain_cycle", 64'(drain_cycle), 64'd9);
    check("starve_empty", 64'(empty), 64'd1);
    tick();

    // Reset with three buffered stores and a load in flight
    ld_valid = 1'b1; ld_addr = 64'h300; st_valid = 1'b1; st_size = 4'd8;
    for (int i = 0; i < 3; i++) begin
      st_addr = 64'h380 + 64'(i * 8); st_data = 64'(i + 1);
      tick();
    end
    st_valid = 1'b0; ld_valid = 1'b0;
    check("pre_rst_empty", 64'(empty), 64'd0);
    check("pre_rst_rvalid", 64'(ld_rvalid), 64'd1);
    wr_before = wr_count;
    rst_n = 1'b0;
    #1;
    check("mid_rst_empty", 64'(empty), 64'd1);
    check("mid_rst_rvalid", 64'(ld_rvalid), 64'd0);
    check("mid_rst_st_ready", 64'(st_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("post_rst_we", 64'(mem_write_enable), 64'd0);
    end
    check("post_rst_writes", 64'(wr_count), 64'(wr_before));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
